// File: rtl/msg_scan_display.sv
// Scans an 8-character letter bus onto a common-anode 7-segment display, snapshotting once per frame.
// Optional MSG_MATCH_EN adds a "WITHDRAW" comparator output `match`.
module msg_scan_display #(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned DIV_W    = 20
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic [39:0] instruction,
  output logic [6:0]  seg,
  output logic [7:0]  an,
  output logic        frame_tick,
  output logic        invalid
`ifdef MSG_MATCH_EN
  ,
  output logic        match
`endif
);

  logic [DIV_W-1:0] prescaler;
  logic [2:0]       idx;
  logic [39:0]      snapshot;
  logic             tick;
  logic             wrap;
  logic [4:0]       code;
  logic [6:0]       glyph;
  logic             inv_next;

  assign tick = (prescaler == DIV_W'(SCAN_DIV - 1));
  assign wrap = tick && (idx == 3'd7);
  assign code = snapshot[5*idx +: 5];

  always_comb begin
    glyph = 7'h00;
    case (code)
      5'd1:  glyph = 7'h77;
      5'd2:  glyph = 7'h7C;
      5'd3:  glyph = 7'h39;
      5'd4:  glyph = 7'h5E;
      5'd5:  glyph = 7'h79;
      5'd6:  glyph = 7'h71;
      5'd7:  glyph = 7'h3D;
      5'd8:  glyph = 7'h76;
      5'd9:  glyph = 7'h06;
      5'd10: glyph = 7'h1E;
      5'd11: glyph = 7'h75;
      5'd12: glyph = 7'h38;
      5'd13: glyph = 7'h37;
      5'd14: glyph = 7'h54;
      5'd15: glyph = 7'h5C;
      5'd16: glyph = 7'h73;
      5'd17: glyph = 7'h67;
      5'd18: glyph = 7'h50;
      5'd19: glyph = 7'h6D;
      5'd20: glyph = 7'h78;
      5'd21: glyph = 7'h3E;
      5'd22: glyph = 7'h1C;
      5'd23: glyph = 7'h2A;
      5'd24: glyph = 7'h64;
      5'd25: glyph = 7'h6E;
      5'd26: glyph = 7'h5B;
      default: glyph = 7'h00;
    endcase
  end

  // Judged on the incoming bus so the flag lands in the same cycle as frame_tick.
  always_comb begin
    inv_next = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (instruction[5*i +: 5] >= 5'd27) inv_next = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      prescaler  <= '0;
      idx        <= '0;
      snapshot   <= '0;
      seg        <= '1;
      an         <= '1;
      frame_tick <= 1'b0;
      invalid    <= 1'b0;
    end else begin
      prescaler  <= tick ? '0 : prescaler + DIV_W'(1);
      if (tick) idx <= idx + 3'd1;
      if (wrap) begin
        snapshot <= instruction;
        invalid  <= inv_next;
      end
      frame_tick <= wrap;
      an         <= ~(8'b1 << idx);
      seg        <= ~glyph;
    end
  end

`ifdef MSG_MATCH_EN
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)    match <= 1'b0;
    else if (wrap) match <= (instruction == 40'hBA68824837);
  end
`endif

endmodule

// File: tb/tb_msg_scan_display.sv
// Directed bench for msg_scan_display: cycle-count based reference model plus literal spot checks.
module tb_msg_scan_display;

  localparam int unsigned SD = 4;
  localparam logic [39:0] WORD  = 40'hBA68824837;
  localparam logic [39:0] ALL_A = 40'h0842108421;
  localparam logic [39:0] BAD4  = 40'h0001F00000;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic [39:0] instruction = '0;
  logic [6:0]  seg;
  logic [7:0]  an;
  logic        frame_tick;
  logic        invalid;
`ifdef MSG_MATCH_EN
  logic        match;
`endif

  msg_scan_display #(.SCAN_DIV(SD), .DIV_W(3)) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .instruction (instruction),
    .seg         (seg),
    .an          (an),
    .frame_tick  (frame_tick),
    .invalid     (invalid)
`ifdef MSG_MATCH_EN
    ,
    .match       (match)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Letter glyphs indexed by code, active-high {g..a}; codes 0 and 27..31 blank.
  logic [6:0] glyph_tab [32] = '{7'h00,
    7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h3D, 7'h76, 7'h06, 7'h1E, 7'h75, 7'h38, 7'h37,
    7'h54, 7'h5C, 7'h73, 7'h67, 7'h50, 7'h6D, 7'h78, 7'h3E, 7'h1C, 7'h2A, 7'h64, 7'h6E, 7'h5B,
    7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

  int          n = 0;
  int          d;
  int          fcode;
  logic [39:0] msnap = '0;
  logic [6:0]  exp_seg = 7'h7F;
  logic [7:0]  exp_an = 8'hFF;
  logic        exp_ft = 1'b0;
  logic        exp_inv = 1'b0;
  logic        exp_match = 1'b0;

  // Outputs after edge n are a function of elapsed cycles and the last frame-boundary sample.
  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      n = 0; msnap = '0;
      exp_seg = 7'h7F; exp_an = 8'hFF; exp_ft = 1'b0; exp_inv = 1'b0; exp_match = 1'b0;
    end else begin
      n++;
      d = ((n - 1) / SD) % 8;
      exp_an = ~(8'd1 << d);
      fcode = int'((msnap >> (5 * d)) & 40'h1F);
      exp_seg = ~glyph_tab[fcode];
      exp_ft = (n % (8 * SD)) == 0;
      if (exp_ft) begin
        msnap = instruction;
        exp_inv = 1'b0;
        for (int k = 0; k < 8; k++)
          if (((instruction >> (5 * k)) & 40'h1F) >= 40'd27) exp_inv = 1'b1;
        exp_match = (instruction == WORD);
      end
    end
  end

  always @(posedge clock) begin
    #2;
    check("model_seg", {57'd0, seg}, {57'd0, exp_seg});
    check("model_an", {56'd0, an}, {56'd0, exp_an});
    check("model_frame_tick", {63'd0, frame_tick}, {63'd0, exp_ft});
    check("model_invalid", {63'd0, invalid}, {63'd0, exp_inv});
`ifdef MSG_MATCH_EN
    check("model_match", {63'd0, match}, {63'd0, exp_match});
`endif
  end

  int cyc = 0;

  task automatic step_to(input int target);
    while (cyc < target) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
    check(name, act, exp);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    lit("rst_seg", {57'd0, seg}, 64'h7F);
    lit("rst_an", {56'd0, an}, 64'hFF);
    rst_n = 1'b1;
    cyc = 0;

    step_to(1);
    lit("first_an", {56'd0, an}, 64'hFE);
    lit("first_seg", {57'd0, seg}, 64'h7F);
    step_to(2);
    instruction = WORD;
    step_to(5);
    lit("walk_an", {56'd0, an}, 64'hFD);
    step_to(31);
    lit("no_tick_31", {63'd0, frame_tick}, 64'd0);
    step_to(32);
    lit("tick_32", {63'd0, frame_tick}, 64'd1);
    lit("word_valid", {63'd0, invalid}, 64'd0);
`ifdef MSG_MATCH_EN
    lit("word_match", {63'd0, match}, 64'd1);
`endif
    step_to(33);
    lit("tick_drop", {63'd0, frame_tick}, 64'd0);
    lit("w_right_seg", {57'd0, seg}, 64'h55);
    step_to(40);
    instruction = ALL_A;
    step_to(57);
    lit("i_an", {56'd0, an}, 64'hBF);
    lit("i_seg", {57'd0, seg}, 64'h79);
    step_to(61);
    lit("w_left_an", {56'd0, an}, 64'h7F);
    lit("w_left_seg_held", {57'd0, seg}, 64'h55);
    step_to(64);
    lit("tick_64", {63'd0, frame_tick}, 64'd1);
`ifdef MSG_MATCH_EN
    lit("match_drop", {63'd0, match}, 64'd0);
`endif
    step_to(65);
    lit("a_seg", {57'd0, seg}, 64'h08);
    step_to(66);
    instruction = BAD4;
    step_to(96);
    lit("invalid_set", {63'd0, invalid}, 64'd1);
    step_to(100);
    instruction = '0;
    step_to(113);
    lit("bad_digit_an", {56'd0, an}, 64'hEF);
    lit("bad_digit_blank", {57'd0, seg}, 64'h7F);
    step_to(128);
    lit("invalid_clear", {63'd0, invalid}, 64'd0);
    step_to(130);
    instruction = WORD;
    step_to(161);
    lit("pre_reset_seg", {57'd0, seg}, 64'h55);
    step_to(182);
    lit("idx5_an", {56'd0, an}, 64'hDF);
    rst_n = 1'b0;
    #1;
    lit("async_an", {56'd0, an}, 64'hFF);
    lit("async_seg", {57'd0, seg}, 64'h7F);
    @(negedge clock);
    rst_n = 1'b1;
    cyc = 0;
    step_to(1);
    lit("restart_an", {56'd0, an}, 64'hFE);
    lit("restart_seg", {57'd0, seg}, 64'h7F);
    step_to(20);
    lit("snap_cleared", {57'd0, seg}, 64'h7F);
    step_to(33);
    lit("rewrap_seg", {57'd0, seg}, 64'h55);
    step_to(40);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
